// File: rtl/gemm_pkg.sv
// Shared types and helpers for the GeMM tile accelerator: FSM state encoding
// and operand extension by signed/unsigned mode.
package gemm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        WRITE,
        FINISH
    } gemm_state_e;

    localparam int ExtW    = 64;
    localparam int ExtIdxW = $clog2(ExtW);

    // Sign- or zero-extends the low w bits of v to ExtW bits.
    function automatic logic [ExtW-1:0] ext_elem(input logic [ExtW-1:0] v,
                                                 input int w,
                                                 input logic is_signed);
        logic [ExtW-1:0] mask;
        mask = (w >= ExtW) ? '1 : ((ExtW'(1) << w) - ExtW'(1));
        if (is_signed && v[ExtIdxW'(w - 1)]) begin
            return v | ~mask;
        end
        return v & mask;
    endfunction

endpackage

// File: rtl/gemm_tile_accelerator_if.sv
// Host control and A/B/C SRAM bus of the GeMM tile accelerator.
// The accelerator connects through the slave modport; host/SRAM side uses master.
interface gemm_tile_accelerator_if #(
    parameter int ArrRows    = 4,
    parameter int ArrCols    = 4,
    parameter int DataWidthA = 8,
    parameter int DataWidthB = 8,
    parameter int DataWidthC = 32,
    parameter int SizeWidth  = 16,
    parameter int AddrWidth  = 16
);
    logic                          start_i;
    logic                          signed_i;
    logic [SizeWidth-1:0]          m_tiles_i;
    logic [SizeWidth-1:0]          k_size_i;
    logic [SizeWidth-1:0]          n_tiles_i;
    logic                          busy_o;
    logic                          done_o;
    logic [AddrWidth-1:0]          sram_a_addr_o;
    logic [ArrRows*DataWidthA-1:0] sram_a_rdata_i;
    logic [AddrWidth-1:0]          sram_b_addr_o;
    logic [ArrCols*DataWidthB-1:0] sram_b_rdata_i;
    logic [AddrWidth-1:0]          sram_c_addr_o;
    logic [ArrCols*DataWidthC-1:0] sram_c_wdata_o;
    logic                          sram_c_we_o;

    modport slave (
        input  start_i, signed_i, m_tiles_i, k_size_i, n_tiles_i,
        input  sram_a_rdata_i, sram_b_rdata_i,
        output busy_o, done_o, sram_a_addr_o, sram_b_addr_o,
        output sram_c_addr_o, sram_c_wdata_o, sram_c_we_o
    );

    modport master (
        output start_i, signed_i, m_tiles_i, k_size_i, n_tiles_i,
        output sram_a_rdata_i, sram_b_rdata_i,
        input  busy_o, done_o, sram_a_addr_o, sram_b_addr_o,
        input  sram_c_addr_o, sram_c_wdata_o, sram_c_we_o
    );
endinterface

// File: rtl/gemm_mac_pe.sv
// One output-stationary MAC processing element: accumulates a*b over K,
// restarting the sum on the first valid beat of each tile.
module gemm_mac_pe
    import gemm_pkg::*;
#(
    parameter int DataWidthA = 8,
    parameter int DataWidthB = 8,
    parameter int DataWidthC = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DataWidthA-1:0] a_i,
    input  logic [DataWidthB-1:0] b_i,
    input  logic                  valid_i,
    input  logic                  first_i,
    input  logic                  signed_i,
    output logic [DataWidthC-1:0] acc_o
);
    logic signed [DataWidthC-1:0] a_ext;
    logic signed [DataWidthC-1:0] b_ext;
    logic signed [DataWidthC-1:0] acc_p1;

    // Extending both operands to the accumulator width first gives the exact
    // product modulo 2^DataWidthC in either mode.
    assign a_ext = DataWidthC'(ext_elem(ExtW'(a_i), DataWidthA, signed_i));
    assign b_ext = DataWidthC'(ext_elem(ExtW'(b_i), DataWidthB, signed_i));

    // Stage p1: accumulate
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_p1 <= '0;
        end else if (valid_i) begin
            acc_p1 <= (first_i ? '0 : acc_p1) + a_ext * b_ext;
        end
    end

    assign acc_o = acc_p1;

endmodule

// File: rtl/gemm_tile_accelerator.sv
// GeMM tile engine: FSM, tile/K/row counters, SRAM address generation and the
// read-valid pipeline feeding an ArrRows x ArrCols array of MAC PEs.
module gemm_tile_accelerator
    import gemm_pkg::*;
#(
    parameter int ArrRows    = 4,
    parameter int ArrCols    = 4,
    parameter int DataWidthA = 8,
    parameter int DataWidthB = 8,
    parameter int DataWidthC = 32,
    parameter int SizeWidth  = 16,
    parameter int AddrWidth  = 16
) (
    input logic                   clk_i,
    input logic                   rst_i,
    gemm_tile_accelerator_if.slave bus
);
    localparam int RW = (ArrRows > 1) ? $clog2(ArrRows) : 1;

    gemm_state_e          state_q, state_d;
    logic [SizeWidth-1:0] m_tiles_q, k_size_q, n_tiles_q;
    logic [SizeWidth-1:0] mt_q, nt_q, k_q;
    logic [RW-1:0]        r_q;
    logic                 signed_q, busy_q, done_q;
    logic                 vld_p0, first_p0;
    logic                 k_last, r_last, nt_last, mt_last, size_zero;
    logic [AddrWidth-1:0] a_addr, b_addr, c_addr, a_addr_hold, b_addr_hold;
    logic [ArrCols*DataWidthC-1:0] c_wdata;
    logic [DataWidthC-1:0] acc [ArrRows][ArrCols];

    assign k_last    = (k_q == k_size_q - SizeWidth'(1));
    assign r_last    = (r_q == RW'(ArrRows - 1));
    assign nt_last   = (nt_q == n_tiles_q - SizeWidth'(1));
    assign mt_last   = (mt_q == m_tiles_q - SizeWidth'(1));
    assign size_zero = (bus.m_tiles_i == '0) || (bus.k_size_i == '0) || (bus.n_tiles_i == '0);

    // Low bits of sums/products depend only on low operand bits, so working
    // modulo 2^AddrWidth equals the full-width result truncated.
    assign a_addr = AddrWidth'(mt_q) * AddrWidth'(k_size_q) + AddrWidth'(k_q);
    assign b_addr = AddrWidth'(k_q) * AddrWidth'(n_tiles_q) + AddrWidth'(nt_q);
    assign c_addr = (AddrWidth'(mt_q) * AddrWidth'(ArrRows) + AddrWidth'(r_q))
                    * AddrWidth'(n_tiles_q) + AddrWidth'(nt_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = size_zero ? FINISH : LOAD;
            LOAD:    if (k_last) state_d = DRAIN;
            DRAIN:   state_d = WRITE;
            WRITE:   if (r_last) state_d = (mt_last && nt_last) ? FINISH : LOAD;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: state, counters and read-return tracking
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            m_tiles_q   <= '0;
            k_size_q    <= '0;
            n_tiles_q   <= '0;
            signed_q    <= 1'b0;
            mt_q        <= '0;
            nt_q        <= '0;
            k_q         <= '0;
            r_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vld_p0      <= 1'b0;
            first_p0    <= 1'b0;
            a_addr_hold <= '0;
            b_addr_hold <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_q == FINISH);
            vld_p0   <= (state_q == LOAD);
            first_p0 <= (state_q == LOAD) && (k_q == '0);
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        m_tiles_q <= bus.m_tiles_i;
                        k_size_q  <= bus.k_size_i;
                        n_tiles_q <= bus.n_tiles_i;
                        signed_q  <= bus.signed_i;
                        mt_q      <= '0;
                        nt_q      <= '0;
                        k_q       <= '0;
                        r_q       <= '0;
                    end
                end
                LOAD: begin
                    k_q         <= k_last ? '0 : k_q + SizeWidth'(1);
                    a_addr_hold <= a_addr;
                    b_addr_hold <= b_addr;
                end
                WRITE: begin
                    r_q <= r_last ? '0 : r_q + RW'(1);
                    if (r_last) begin
                        if (nt_last) begin
                            nt_q <= '0;
                            mt_q <= mt_last ? '0 : mt_q + SizeWidth'(1);
                        end else begin
                            nt_q <= nt_q + SizeWidth'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gr = 0; gr < ArrRows; gr++) begin : g_row
        for (genvar gc = 0; gc < ArrCols; gc++) begin : g_col
            gemm_mac_pe #(
                .DataWidthA(DataWidthA),
                .DataWidthB(DataWidthB),
                .DataWidthC(DataWidthC)
            ) u_pe (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .a_i     (bus.sram_a_rdata_i[gr*DataWidthA +: DataWidthA]),
                .b_i     (bus.sram_b_rdata_i[gc*DataWidthB +: DataWidthB]),
                .valid_i (vld_p0),
                .first_i (first_p0),
                .signed_i(signed_q),
                .acc_o   (acc[gr][gc])
            );
        end
    end

    always_comb begin
        c_wdata = '0;
        if (state_q == WRITE) begin
            for (int c = 0; c < ArrCols; c++) begin
                c_wdata[c*DataWidthC +: DataWidthC] = acc[r_q][c];
            end
        end
    end

    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign bus.sram_a_addr_o  = (state_q == LOAD) ? a_addr : a_addr_hold;
    assign bus.sram_b_addr_o  = (state_q == LOAD) ? b_addr : b_addr_hold;
    assign bus.sram_c_we_o    = (state_q == WRITE);
    assign bus.sram_c_addr_o  = (state_q == WRITE) ? c_addr : '0;
    assign bus.sram_c_wdata_o = c_wdata;

endmodule

// File: tb/tb_gemm_tile_accelerator.sv
// Bench for gemm_tile_accelerator: 2x2 arrays with 32-bit and 16-bit accumulators,
// behavioural A/B SRAMs and a scoreboard of expected C writes.
module tb_gemm_tile_accelerator;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   s_cyc = 0;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [79:0] exp1[$], obs1[$];
    logic [47:0] exp2[$], obs2[$];

    gemm_tile_accelerator_if #(.ArrRows(2), .ArrCols(2), .DataWidthA(8), .DataWidthB(8),
        .DataWidthC(32), .SizeWidth(16), .AddrWidth(16)) bus1 ();
    gemm_tile_accelerator_if #(.ArrRows(2), .ArrCols(2), .DataWidthA(8), .DataWidthB(8),
        .DataWidthC(16), .SizeWidth(16), .AddrWidth(16)) bus2 ();

    gemm_tile_accelerator #(.ArrRows(2), .ArrCols(2), .DataWidthA(8), .DataWidthB(8),
        .DataWidthC(32), .SizeWidth(16), .AddrWidth(16)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
    gemm_tile_accelerator #(.ArrRows(2), .ArrCols(2), .DataWidthA(8), .DataWidthB(8),
        .DataWidthC(16), .SizeWidth(16), .AddrWidth(16)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        bus1.sram_a_rdata_i <= mem_a[bus1.sram_a_addr_o[7:0]];
        bus1.sram_b_rdata_i <= mem_b[bus1.sram_b_addr_o[7:0]];
        bus2.sram_a_rdata_i <= mem_a[bus2.sram_a_addr_o[7:0]];
        bus2.sram_b_rdata_i <= mem_b[bus2.sram_b_addr_o[7:0]];
    end

    always @(negedge clk) begin
        if (bus1.sram_c_we_o === 1'b1) obs1.push_back({bus1.sram_c_addr_o, bus1.sram_c_wdata_o});
        if (bus2.sram_c_we_o === 1'b1) obs2.push_back({bus2.sram_c_addr_o, bus2.sram_c_wdata_o});
    end

    function automatic logic [31:0] model_elem(int mt, int nt, int r, int c, int k_sz, int n_t, bit sgn);
        int acc = 0;
        for (int k = 0; k < k_sz; k++) begin
            logic [15:0] aw, bw;
            logic [7:0]  a8, b8;
            int ai, bi;
            aw = mem_a[mt*k_sz + k];
            bw = mem_b[k*n_t + nt];
            a8 = aw[r*8 +: 8];
            b8 = bw[c*8 +: 8];
            ai = sgn ? int'($signed(a8)) : int'(a8);
            bi = sgn ? int'($signed(b8)) : int'(b8);
            acc += ai * bi;
        end
        return acc;
    endfunction

    task automatic push_model1(int m_t, int n_t, int k_sz, bit sgn);
        for (int mt = 0; mt < m_t; mt++)
            for (int nt = 0; nt < n_t; nt++)
                for (int r = 0; r < 2; r++)
                    exp1.push_back({16'((mt*2 + r)*n_t + nt),
                                    model_elem(mt, nt, r, 1, k_sz, n_t, sgn),
                                    model_elem(mt, nt, r, 0, k_sz, n_t, sgn)});
    endtask

    task automatic start1(int m_t, int k_sz, int n_t, bit sgn);
        @(posedge clk);
        #1;
        bus1.m_tiles_i = 16'(m_t);
        bus1.k_size_i  = 16'(k_sz);
        bus1.n_tiles_i = 16'(n_t);
        bus1.signed_i  = sgn;
        bus1.start_i   = 1'b1;
        @(posedge clk);
        #1;
        s_cyc = cyc;
        bus1.start_i   = 1'b0;
        bus1.m_tiles_i = 16'($urandom);
        bus1.k_size_i  = 16'($urandom);
        bus1.n_tiles_i = 16'($urandom);
        bus1.signed_i  = 1'($urandom);
    endtask

    // Waits for done_o; lat = cycles after the start cycle (-1 on timeout).
    task automatic wait_done1(input int budget, output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus1.done_o === 1'b1) begin
                lat = cyc - s_cyc + 1;
                if (bus1.busy_o !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (bus1.busy_o !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic load_basic();
        mem_a[0] = 16'h0301; mem_a[1] = 16'h0402;
        mem_b[0] = 16'h0605; mem_b[1] = 16'h0807;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus1.busy_o, bus1.done_o, bus1.sram_c_we_o} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl busy/done/we=%b want 000", {bus1.busy_o, bus1.done_o, bus1.sram_c_we_o});
        end
        total++;
        if ({bus1.sram_a_addr_o, bus1.sram_b_addr_o, bus1.sram_c_addr_o} !== 48'd0) begin
            bad++; $display("FAIL reset_addr got=%h want 0", {bus1.sram_a_addr_o, bus1.sram_b_addr_o, bus1.sram_c_addr_o});
        end
        total++;
        if (bus1.sram_c_wdata_o !== 64'd0) begin
            bad++; $display("FAIL reset_wdata got=%h want 0", bus1.sram_c_wdata_o);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; bit bok;
        logic [79:0] e, o;
        load_basic();
        exp1.push_back({16'd0, 32'd22, 32'd19});
        exp1.push_back({16'd1, 32'd50, 32'd43});
        start1(1, 2, 1, 1'b0);
        wait_done1(100, lat, bok);
        total++;
        if (lat !== 7) begin bad++; $display("FAIL basic_latency got=%0d want=7", lat); end
        total++;
        if (!bok) begin bad++; $display("FAIL basic_busy got=0 want=1"); end
        total++;
        if (obs1.size() !== exp1.size()) begin
            bad++; $display("FAIL basic_count got=%0d want=%0d", obs1.size(), exp1.size());
        end
        while (exp1.size() > 0 && obs1.size() > 0) begin
            e = exp1.pop_front(); o = obs1.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL basic_write got=%h want=%h", o, e); end
        end
        exp1.delete(); obs1.delete();
    endtask

    task automatic test_signed_modes();
        int lat; bit bok;
        logic [79:0] e, o;
        mem_a[0] = 16'h00FF; mem_a[1] = 16'hFF00;
        mem_b[0] = 16'hFD02; mem_b[1] = 16'h0504;
        for (int mode = 1; mode >= 0; mode--) begin
            if (mode == 1) begin
                exp1.push_back({16'd0, 32'd3, 32'hFFFF_FFFE});
                exp1.push_back({16'd1, 32'hFFFF_FFFB, 32'hFFFF_FFFC});
            end else begin
                exp1.push_back({16'd0, 32'd64515, 32'd510});
                exp1.push_back({16'd1, 32'd1275, 32'd1020});
            end
            start1(1, 2, 1, 1'(mode));
            wait_done1(100, lat, bok);
            total++;
            if (lat !== 7) begin bad++; $display("FAIL signed%0d_latency got=%0d want=7", mode, lat); end
            total++;
            if (obs1.size() !== exp1.size()) begin
                bad++; $display("FAIL signed%0d_count got=%0d want=%0d", mode, obs1.size(), exp1.size());
            end
            while (exp1.size() > 0 && obs1.size() > 0) begin
                e = exp1.pop_front(); o = obs1.pop_front(); total++;
                if (o !== e) begin bad++; $display("FAIL signed%0d_write got=%h want=%h", mode, o, e); end
            end
            exp1.delete(); obs1.delete();
        end
    endtask

    task automatic test_multi_tile();
        int lat; bit bok;
        logic [79:0] e, o;
        for (int i = 0; i < 6; i++) begin
            mem_a[i] = 16'($urandom);
            mem_b[i] = 16'($urandom);
        end
        push_model1(2, 2, 3, 1'b1);
        start1(2, 3, 2, 1'b1);
        wait_done1(200, lat, bok);
        total++;
        if (lat !== 26) begin bad++; $display("FAIL multi_latency got=%0d want=26", lat); end
        total++;
        if (!bok) begin bad++; $display("FAIL multi_busy got=0 want=1"); end
        total++;
        if (obs1.size() !== exp1.size()) begin
            bad++; $display("FAIL multi_count got=%0d want=%0d", obs1.size(), exp1.size());
        end
        while (exp1.size() > 0 && obs1.size() > 0) begin
            e = exp1.pop_front(); o = obs1.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL multi_write got=%h want=%h", o, e); end
        end
        exp1.delete(); obs1.delete();
    endtask

    task automatic test_zero_size();
        int lat; bit bok;
        for (int z = 0; z < 3; z++) begin
            start1(z == 0 ? 0 : 1, z == 1 ? 0 : 2, z == 2 ? 0 : 1, 1'b0);
            wait_done1(50, lat, bok);
            total++;
            if (lat !== 2) begin bad++; $display("FAIL zero%0d_latency got=%0d want=2", z, lat); end
            repeat (3) @(negedge clk);
            total++;
            if (obs1.size() !== 0) begin bad++; $display("FAIL zero%0d_writes got=%0d want=0", z, obs1.size()); end
            obs1.delete();
        end
    endtask

    task automatic test_start_while_busy();
        int lat, extra; bit bok;
        logic [79:0] e, o;
        load_basic();
        exp1.push_back({16'd0, 32'd22, 32'd19});
        exp1.push_back({16'd1, 32'd50, 32'd43});
        start1(1, 2, 1, 1'b0);
        @(posedge clk);
        #1 bus1.start_i = 1'b1; bus1.k_size_i = 16'd0;
        @(posedge clk);
        #1 bus1.start_i = 1'b0;
        wait_done1(100, lat, bok);
        total++;
        if (lat !== 7) begin bad++; $display("FAIL busy_start_latency got=%0d want=7", lat); end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus1.done_o === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL busy_start_extra_done got=%0d want=0", extra); end
        total++;
        if (obs1.size() !== exp1.size()) begin
            bad++; $display("FAIL busy_start_count got=%0d want=%0d", obs1.size(), exp1.size());
        end
        while (exp1.size() > 0 && obs1.size() > 0) begin
            e = exp1.pop_front(); o = obs1.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL busy_start_write got=%h want=%h", o, e); end
        end
        exp1.delete(); obs1.delete();
    endtask

    task automatic test_wrap();
        int lat;
        logic [47:0] e, o;
        mem_a[0] = 16'hFFFF; mem_a[1] = 16'hFFFF;
        mem_b[0] = 16'hFFFF; mem_b[1] = 16'hFFFF;
        exp2.push_back({16'd0, 16'd64514, 16'd64514});
        exp2.push_back({16'd1, 16'd64514, 16'd64514});
        @(posedge clk);
        #1;
        bus2.m_tiles_i = 16'd1; bus2.k_size_i = 16'd2; bus2.n_tiles_i = 16'd1;
        bus2.signed_i = 1'b0; bus2.start_i = 1'b1;
        @(posedge clk);
        #1 s_cyc = cyc; bus2.start_i = 1'b0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus2.done_o === 1'b1) begin lat = cyc - s_cyc + 1; break; end
        end
        total++;
        if (lat !== 7) begin bad++; $display("FAIL wrap_latency got=%0d want=7", lat); end
        total++;
        if (obs2.size() !== exp2.size()) begin
            bad++; $display("FAIL wrap_count got=%0d want=%0d", obs2.size(), exp2.size());
        end
        while (exp2.size() > 0 && obs2.size() > 0) begin
            e = exp2.pop_front(); o = obs2.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL wrap_write got=%h want=%h", o, e); end
        end
        exp2.delete(); obs2.delete();
    endtask

    task automatic test_reset_mid_load();
        int lat, dones; bit bok;
        logic [79:0] e, o;
        start1(1, 5, 1, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bus1.busy_o, bus1.done_o, bus1.sram_c_we_o, bus1.sram_a_addr_o, bus1.sram_b_addr_o} !== 35'd0) begin
            bad++; $display("FAIL midrst_outputs got=%h want=0",
                {bus1.busy_o, bus1.done_o, bus1.sram_c_we_o, bus1.sram_a_addr_o, bus1.sram_b_addr_o});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus1.done_o === 1'b1) dones++;
        end
        total++;
        if (dones !== 0 || obs1.size() !== 0) begin
            bad++; $display("FAIL midrst_abort got done=%0d writes=%0d want 0/0", dones, obs1.size());
        end
        obs1.delete();
        load_basic();
        exp1.push_back({16'd0, 32'd22, 32'd19});
        exp1.push_back({16'd1, 32'd50, 32'd43});
        start1(1, 2, 1, 1'b0);
        wait_done1(100, lat, bok);
        total++;
        if (lat !== 7) begin bad++; $display("FAIL midrst_restart_latency got=%0d want=7", lat); end
        total++;
        if (obs1.size() !== exp1.size()) begin
            bad++; $display("FAIL midrst_count got=%0d want=%0d", obs1.size(), exp1.size());
        end
        while (exp1.size() > 0 && obs1.size() > 0) begin
            e = exp1.pop_front(); o = obs1.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL midrst_write got=%h want=%h", o, e); end
        end
        exp1.delete(); obs1.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        bus1.start_i = 1'b0; bus1.signed_i = 1'b0;
        bus1.m_tiles_i = '0; bus1.k_size_i = '0; bus1.n_tiles_i = '0;
        bus2.start_i = 1'b0; bus2.signed_i = 1'b0;
        bus2.m_tiles_i = '0; bus2.k_size_i = '0; bus2.n_tiles_i = '0;
        test_reset();
        test_basic();
        test_signed_modes();
        test_multi_tile();
        test_zero_size();
        test_start_while_busy();
        test_wrap();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
